// File: rtl/cmd_pulsegen_if.sv
// Front-panel command bus: raw button levels and running flag in,
// one-cycle command pulses and debounced levels out.
interface cmd_pulsegen_if;
    logic       btn_run;
    logic       btn_step_phase;
    logic       btn_step_inst;
    logic       running;
    logic       run;
    logic       step_phase;
    logic       step_inst;
    logic [2:0] btn_level;

    modport master (
        output btn_run, btn_step_phase, btn_step_inst, running,
        input  run, step_phase, step_inst, btn_level
    );

    modport slave (
        input  btn_run, btn_step_phase, btn_step_inst, running,
        output run, step_phase, step_inst, btn_level
    );
endinterface

// File: rtl/cmd_pulsegen.sv
// Synchronizes and debounces three push buttons and turns each accepted press
// into a single-cycle, priority-arbitrated command pulse for the phase generator.
module cmd_pulsegen #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic          clock,
    input  logic          reset,
    cmd_pulsegen_if.slave bus
);
    localparam int NUM_CH = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: 0 = run, 1 = step_phase, 2 = step_inst
    logic [NUM_CH-1:0]            s1_q, s1_d;
    logic [NUM_CH-1:0]            s2_q, s2_d;
    logic [NUM_CH-1:0]            db_q, db_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            pulse_q, pulse_d;
    logic [NUM_CH-1:0]            press;
    logic [NUM_CH-1:0]            cand;

    always_comb begin
        s1_d  = {bus.btn_step_inst, bus.btn_step_phase, bus.btn_run};
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = cnt_q;
        press = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
                press[i] = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // Step requests are dropped, not deferred, while free-running
        cand       = press;
        cand[1]    = press[1] & ~bus.running;
        cand[2]    = press[2] & ~bus.running;

        pulse_d    = '0;
        pulse_d[0] = cand[0];
        pulse_d[1] = cand[1] & ~cand[0];
        pulse_d[2] = cand[2] & ~cand[1] & ~cand[0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.run        = pulse_q[0];
    assign bus.step_phase = pulse_q[1];
    assign bus.step_inst  = pulse_q[2];
    assign bus.btn_level  = db_q;
endmodule

// File: doc/cmd_pulsegen.md
# cmd_pulsegen

Front-panel command conditioner sitting directly upstream of the phase generator. It takes the three raw push-button levels (run, step-phase, step-instruction), then synchronizes and debounces each one. On each debounced press it emits a single-cycle, mutually exclusive command pulse on `run` / `step_phase` / `step_inst`, which drive the phase generator's inputs of the same names. It uses the phase generator's `running` output to drop step requests that would otherwise be lost while the CPU is free-running.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronized level must differ from the debounced level before it is accepted (5 ms at 50 MHz); legal range 1 .. 2^`CNT_W`-1.
- `CNT_W`, default 18: width of each debounce counter.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_run`  in  1  raw run button, asynchronous, 1 = pressed.
- `btn_step_phase`  in  1  raw step-phase button, asynchronous, 1 = pressed.
- `btn_step_inst`  in  1  raw step-instruction button, asynchronous, 1 = pressed.
- `running`  in  1  phase-generator running flag.
- `run`  out  1  one-cycle run/stop toggle request.
- `step_phase`  out  1  one-cycle single-phase request.
- `step_inst`  out  1  one-cycle single-instruction request.
- `btn_level`  out  3  debounced levels {step_inst, step_phase, run}, for LEDs and debug.

## Operation
- The following is identical for each of the 3 channels: a 2-flop synchronizer (`s1` then `s2`), a debounced level `db`, and a counter `cnt`.
- If `s2 == db`: `cnt <= 0`.
- If `s2 != db` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
- If `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0`. This is the accept event.
- Any glitch shorter than `DEBOUNCE_CYCLES` at `s2` clears the counter and changes nothing.
- A rising accept (`db` goes 0→1) is a press and is a pulse candidate.
- A falling accept (release) updates `db` only; it never produces a pulse.
- Arbitration among candidates in the same cycle: priority is `run` > `step_phase` > `step_inst`.
  - Only the winning pulse is emitted.
  - Losing channels still update `db`. Their press is consumed and does not pulse later; the user must release and press again.
- Gating:
  - `step_phase` and `step_inst` candidates are suppressed when `running == 1` in the accept cycle. The press is consumed, with no deferral.
  - `run` is never gated.
- Invariant: at most one of `run`, `step_phase`, `step_inst` is high in any cycle, and no output is high for 2 consecutive cycles.
- `btn_level` = {db_step_inst, db_step_phase, db_run}.

## Timing
- Reset (synchronous): all `s1`, `s2`, `db`, `cnt` and pulse registers clear to 0.
  - Reset outputs: `run` = `step_phase` = `step_inst` = 0, `btn_level` = 3'b000.
  - Reset mid-count discards any partial debounce.
- Pulse outputs are registered and are computed at the accept edge.
- Press latency: let edge k be the first edge at which `s1` samples 1 with the button held steady.
  - `s2` = 1 after edge k+1.
  - The accept occurs at edge k+1+`DEBOUNCE_CYCLES`.
  - The pulse is high for exactly the cycle following that edge.
  - `btn_level` bit rises at the same edge as the pulse.
- Release latency: same count; `btn_level` bit falls at edge k+1+`DEBOUNCE_CYCLES`; no pulse.
- Button held through reset: `db` = 0 after reset, so one press pulse is produced `DEBOUNCE_CYCLES`+2 edges after `reset` falls. This is intended.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- `DEBOUNCE_CYCLES == 1`: the accept happens on the first edge that `s2` differs from `db`.
- `running` is sampled in the accept cycle only. Its value in any other cycle has no effect.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `CNT_W=3`.
- **Clean press.** Hold `reset` 2 cycles. Raise `btn_run`, first sampled at edge k, and hold it → `run` is high only during the cycle after edge k+5, then `btn_level[0]` = 1. Release the button → `btn_level[0]` = 0 after the matching delay, with no pulse.
- **Bounce rejection.** Toggle `btn_step_phase` high 3 cycles, low 1, high 2, low → no pulse, `btn_level` stays 0. Then hold it high 4+ cycles → exactly one `step_phase` pulse.
- **Simultaneous press.** Raise `btn_run` and `btn_step_inst` on the same cycle → only `run` pulses; `btn_level` = 3'b101. Holding both produces no further pulse.
- **Running gate.** With `running` = 1, press `btn_step_inst` → no `step_inst` pulse, `btn_level[2]` = 1. Drop `running` while still holding → still no pulse. Release and re-press with `running` = 0 → one pulse.
- **Reset mid-operation.** Hold `btn_step_phase`, assert `reset` for 1 cycle at count 2 → all outputs are 0 the next cycle. After `reset` falls, with the button still held, one `step_phase` pulse appears 6 edges later.
- **Repetition.** Run 10 press/release cycles on each button with random bounce under 4 cycles → exactly 10 pulses per channel, and the one-hot / no-back-to-back invariant is asserted every cycle.
